// File: rtl/vga_if.sv
// VGA pixel-stream bundle passed between stages of the video chain:
// scan position, sync, blanking and 12-bit RGB for one pixel per clock.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic [11:0] rgb;

  // A stage receives on "in" and drives on "out".
  modport in  (input  hcount, vcount, hsync, vsync, blank, rgb);
  modport out (output hcount, vcount, hsync, vsync, blank, rgb);
endinterface

// File: rtl/draw_pellets.sv
// Pellet layer for the maze game. Keeps one flag per grid cell, refills the
// grid on level_start, clears cells as the player passes over them and
// overlays the remaining pellets onto the video stream (2-clk latency).
// Optional feature: define DRAW_PELLETS_POWER_EN to make the four corner
// cells power pellets (double-size drawing plus a power_eaten pulse).
module draw_pellets #(
  parameter int          CELL_SIZE   = 32,
  parameter int          GRID_COLS   = 32,
  parameter int          GRID_ROWS   = 24,
  parameter int          PELLET_SIZE = 4,
  parameter logic [11:0] PELLET_RGB  = 12'hFB8,
  localparam int         TOTAL       = GRID_COLS * GRID_ROWS,
  localparam int         LEFT_W      = $clog2(TOTAL + 1)
) (
  input  logic              clk,
  input  logic              rst,
  vga_if.in                 vga_in,
  vga_if.out                vga_out,
  input  logic              level_start,
  input  logic              player_valid,
  input  logic [10:0]       player_x,
  input  logic [10:0]       player_y,
  output logic              pellet_eaten,
  output logic [LEFT_W-1:0] pellets_left,
  output logic              level_clear
`ifdef DRAW_PELLETS_POWER_EN
  ,
  output logic              power_eaten
`endif
);

  localparam int LOG_CELL = $clog2(CELL_SIZE);
  localparam int IDX_W    = $clog2(TOTAL);

  localparam logic [10:0] COLS_L = 11'(GRID_COLS);
  localparam logic [10:0] ROWS_L = 11'(GRID_ROWS);

  // Drawing window inside a cell, one bit wider than the offset so the
  // upper bound never wraps.
  localparam logic [LOG_CELL:0] PEL_LO = (LOG_CELL+1)'(CELL_SIZE/2 - PELLET_SIZE/2);
  localparam logic [LOG_CELL:0] PEL_HI = (LOG_CELL+1)'(CELL_SIZE/2 + PELLET_SIZE/2);
`ifdef DRAW_PELLETS_POWER_EN
  localparam logic [LOG_CELL:0] PWR_LO = (LOG_CELL+1)'(CELL_SIZE/2 - PELLET_SIZE);
  localparam logic [LOG_CELL:0] PWR_HI = (LOG_CELL+1)'(CELL_SIZE/2 + PELLET_SIZE);
`endif

  typedef enum logic [1:0] {IDLE, FILL, PLAY, CLEAR} state_t;

  state_t           state;
  logic [IDX_W-1:0] fill_cnt;
  logic [TOTAL-1:0] flags;

  // Player position to cell; the index is a constant multiply plus add.
  logic [10:0]      eat_col;
  logic [10:0]      eat_row;
  logic             eat_in_grid;
  logic [IDX_W-1:0] eat_idx;
  logic             eat_hit;
`ifdef DRAW_PELLETS_POWER_EN
  logic             eat_corner;
`endif

  // Decode the player sample into a grid cell and decide whether it eats.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    eat_col     = player_x >> LOG_CELL;
    eat_row     = player_y >> LOG_CELL;
    eat_in_grid = (eat_col < COLS_L) && (eat_row < ROWS_L);
    eat_idx     = IDX_W'(eat_row) * IDX_W'(GRID_COLS) + IDX_W'(eat_col);
    eat_hit     = player_valid && eat_in_grid && flags[eat_idx];
`ifdef DRAW_PELLETS_POWER_EN
    eat_corner  = (eat_col == 11'd0 || eat_col == COLS_L - 11'd1) &&
                  (eat_row == 11'd0 || eat_row == ROWS_L - 11'd1);
`endif
  end

  // Game FSM: refill, eat and level-clear bookkeeping with registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the flag grid is a flop vector, not a RAM, so it can and must reset to empty.
      state        <= IDLE;
      fill_cnt     <= '0;
      flags        <= '0;
      pellets_left <= '0;
      pellet_eaten <= 1'b0;
      level_clear  <= 1'b0;
`ifdef DRAW_PELLETS_POWER_EN
      power_eaten  <= 1'b0;
`endif
    end else begin
      pellet_eaten <= 1'b0;
`ifdef DRAW_PELLETS_POWER_EN
      power_eaten  <= 1'b0;
`endif
      if (level_start) begin
        // Restart from any state; existing flags stay until the fill reaches them.
        state       <= FILL;
        fill_cnt    <= '0;
        level_clear <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end
          FILL: begin
            flags[fill_cnt] <= 1'b1;
            if (fill_cnt == IDX_W'(TOTAL - 1)) begin
              state        <= PLAY;
              pellets_left <= LEFT_W'(TOTAL);
            end else begin
              fill_cnt <= fill_cnt + IDX_W'(1);
            end
          end
          PLAY: begin
            if (eat_hit) begin
              flags[eat_idx] <= 1'b0;
              pellet_eaten   <= 1'b1;
`ifdef DRAW_PELLETS_POWER_EN
              power_eaten    <= eat_corner;
`endif
              if (pellets_left != '0) begin
                pellets_left <= pellets_left - LEFT_W'(1);
              end
              if (pellets_left == LEFT_W'(1)) begin
                state       <= CLEAR;
                level_clear <= 1'b1;
              end
            end
          end
          CLEAR: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Scan position to cell index, grid membership and in-cell offset.
  logic [10:0]      pix_col;
  logic [10:0]      pix_row;
  logic             pix_in_grid;
  logic [IDX_W-1:0] pix_idx;

  // Decode the incoming scan position.
  always_comb begin
    pix_col     = vga_in.hcount >> LOG_CELL;
    pix_row     = vga_in.vcount >> LOG_CELL;
    pix_in_grid = (pix_col < COLS_L) && (pix_row < ROWS_L);
    pix_idx     = IDX_W'(pix_row) * IDX_W'(GRID_COLS) + IDX_W'(pix_col);
  end

  logic [10:0]         s1_hcount;
  logic [10:0]         s1_vcount;
  logic                s1_hsync;
  logic                s1_vsync;
  logic                s1_blank;
  logic [11:0]         s1_rgb;
  logic                s1_in_grid;
  logic [IDX_W-1:0]    s1_idx;
  logic [LOG_CELL-1:0] s1_off_x;
  logic [LOG_CELL-1:0] s1_off_y;
`ifdef DRAW_PELLETS_POWER_EN
  logic                s1_corner;
`endif

  // Stage 1: register timing, input colour and the decoded cell position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hcount  <= '0;
      s1_vcount  <= '0;
      s1_hsync   <= 1'b0;
      s1_vsync   <= 1'b0;
      s1_blank   <= 1'b0;
      s1_rgb     <= '0;
      s1_in_grid <= 1'b0;
      s1_idx     <= '0;
      s1_off_x   <= '0;
      s1_off_y   <= '0;
`ifdef DRAW_PELLETS_POWER_EN
      s1_corner  <= 1'b0;
`endif
    end else begin
      s1_hcount  <= vga_in.hcount;
      s1_vcount  <= vga_in.vcount;
      s1_hsync   <= vga_in.hsync;
      s1_vsync   <= vga_in.vsync;
      s1_blank   <= vga_in.blank;
      s1_rgb     <= vga_in.rgb;
      s1_in_grid <= pix_in_grid;
      s1_idx     <= pix_idx;
      s1_off_x   <= vga_in.hcount[LOG_CELL-1:0];
      s1_off_y   <= vga_in.vcount[LOG_CELL-1:0];
`ifdef DRAW_PELLETS_POWER_EN
      s1_corner  <= (pix_col == 11'd0 || pix_col == COLS_L - 11'd1) &&
                    (pix_row == 11'd0 || pix_row == ROWS_L - 11'd1);
`endif
    end
  end

  logic [LOG_CELL:0] win_lo;
  logic [LOG_CELL:0] win_hi;
  logic              overlay;

  // Pellet hit test; flags are read live so an eaten pellet vanishes at once.
  always_comb begin
`ifdef DRAW_PELLETS_POWER_EN
    win_lo = s1_corner ? PWR_LO : PEL_LO;
    win_hi = s1_corner ? PWR_HI : PEL_HI;
`else
    win_lo = PEL_LO;
    win_hi = PEL_HI;
`endif
    overlay = !s1_blank && s1_in_grid && flags[s1_idx] &&
              ({1'b0, s1_off_x} >= win_lo) && ({1'b0, s1_off_x} < win_hi) &&
              ({1'b0, s1_off_y} >= win_lo) && ({1'b0, s1_off_y} < win_hi);
  end

  // Stage 2: output register with the pellet overlay applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.blank  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= s1_hcount;
      vga_out.vcount <= s1_vcount;
      vga_out.hsync  <= s1_hsync;
      vga_out.vsync  <= s1_vsync;
      vga_out.blank  <= s1_blank;
      vga_out.rgb    <= overlay ? PELLET_RGB : s1_rgb;
    end
  end

endmodule

// File: tb/tb_draw_pellets.sv
// Self-checking bench for draw_pellets: a cell-level game model and a
// two-deep video model are compared against the DUT on every falling edge,
// with literal expectations at the key points of each scenario.
module tb_draw_pellets;

  localparam int          CELL_SIZE   = 32;
  localparam int          GRID_COLS   = 32;
  localparam int          GRID_ROWS   = 24;
  localparam int          PELLET_SIZE = 4;
  localparam logic [11:0] PELLET_RGB  = 12'hFB8;
  localparam int          TOTAL       = GRID_COLS * GRID_ROWS;
  localparam int          LEFT_W      = $clog2(TOTAL + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              level_start = 1'b0;
  logic              player_valid = 1'b0;
  logic [10:0]       player_x = '0;
  logic [10:0]       player_y = '0;
  logic              pellet_eaten;
  logic [LEFT_W-1:0] pellets_left;
  logic              level_clear;
`ifdef DRAW_PELLETS_POWER_EN
  logic              power_eaten;
`endif

  vga_if vin();
  vga_if vout();

  draw_pellets #(
    .CELL_SIZE  (CELL_SIZE),
    .GRID_COLS  (GRID_COLS),
    .GRID_ROWS  (GRID_ROWS),
    .PELLET_SIZE(PELLET_SIZE),
    .PELLET_RGB (PELLET_RGB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vga_in      (vin),
    .vga_out     (vout),
    .level_start (level_start),
    .player_valid(player_valid),
    .player_x    (player_x),
    .player_y    (player_y),
    .pellet_eaten(pellet_eaten),
    .pellets_left(pellets_left),
    .level_clear (level_clear)
`ifdef DRAW_PELLETS_POWER_EN
    ,
    .power_eaten (power_eaten)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [TOTAL-1:0] m_flags = '0;
  int             m_left = 0;
  bit             m_filling = 0, m_playing = 0, m_clear = 0;
  int             m_fill_pos = 0;
  bit             m_eat = 0, m_pow = 0;
  int             m_c, m_r;
  // Pixel seen at the previous edge, and the expected output for the one before.
  int             p_h = 0, p_v = 0;
  bit             p_hs = 0, p_vs = 0, p_bl = 0;
  logic [11:0]    p_rgb = '0;
  int             e_h = 0, e_v = 0;
  bit             e_hs = 0, e_vs = 0, e_bl = 0;
  logic [11:0]    e_rgb = '0;

  function automatic bit is_corner(input int c, input int r);
`ifdef DRAW_PELLETS_POWER_EN
    return (c == 0 || c == GRID_COLS - 1) && (r == 0 || r == GRID_ROWS - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [11:0] pixel_colour(input int x, input int y, input bit bl,
                                               input logic [11:0] rgb);
    int c, r, ox, oy, half;
    if (bl || x >= GRID_COLS * CELL_SIZE || y >= GRID_ROWS * CELL_SIZE) return rgb;
    c = x / CELL_SIZE;
    r = y / CELL_SIZE;
    if (!m_flags[r * GRID_COLS + c]) return rgb;
    half = is_corner(c, r) ? PELLET_SIZE : PELLET_SIZE / 2;
    ox = x % CELL_SIZE;
    oy = y % CELL_SIZE;
    if (ox >= CELL_SIZE / 2 - half && ox < CELL_SIZE / 2 + half &&
        oy >= CELL_SIZE / 2 - half && oy < CELL_SIZE / 2 + half) return PELLET_RGB;
    return rgb;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_flags = '0; m_left = 0; m_filling = 0; m_playing = 0; m_clear = 0;
      m_fill_pos = 0; m_eat = 0; m_pow = 0;
      p_h = 0; p_v = 0; p_hs = 0; p_vs = 0; p_bl = 0; p_rgb = '0;
      e_h = 0; e_v = 0; e_hs = 0; e_vs = 0; e_bl = 0; e_rgb = '0;
    end else begin
      // Output now shows the pixel captured one edge ago, drawn with the flags as they stand.
      e_h = p_h; e_v = p_v; e_hs = p_hs; e_vs = p_vs; e_bl = p_bl;
      e_rgb = pixel_colour(p_h, p_v, p_bl, p_rgb);
      p_h = int'(vin.hcount); p_v = int'(vin.vcount);
      p_hs = vin.hsync; p_vs = vin.vsync; p_bl = vin.blank; p_rgb = vin.rgb;
      m_eat = 0;
      m_pow = 0;
      if (level_start) begin
        m_filling = 1; m_fill_pos = 0; m_playing = 0; m_clear = 0;
      end else if (m_filling) begin
        m_flags[m_fill_pos] = 1'b1;
        m_fill_pos++;
        if (m_fill_pos == TOTAL) begin
          m_filling = 0; m_playing = 1; m_left = TOTAL;
        end
      end else if (m_playing && player_valid) begin
        m_c = int'(player_x) / CELL_SIZE;
        m_r = int'(player_y) / CELL_SIZE;
        if (m_c < GRID_COLS && m_r < GRID_ROWS && m_flags[m_r * GRID_COLS + m_c]) begin
          m_flags[m_r * GRID_COLS + m_c] = 1'b0;
          m_left--;
          m_eat = 1;
          m_pow = is_corner(m_c, m_r);
          if (m_left == 0) begin
            m_playing = 0; m_clear = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("hcount", 32'(vout.hcount), e_h);
      check("vcount", 32'(vout.vcount), e_v);
      check("hsync", 32'(vout.hsync), 32'(e_hs));
      check("vsync", 32'(vout.vsync), 32'(e_vs));
      check("blank", 32'(vout.blank), 32'(e_bl));
      check("rgb", 32'(vout.rgb), 32'(e_rgb));
      check("pellet_eaten", 32'(pellet_eaten), 32'(m_eat));
      check("pellets_left", 32'(pellets_left), m_left);
      check("level_clear", 32'(level_clear), 32'(m_clear));
`ifdef DRAW_PELLETS_POWER_EN
      check("power_eaten", 32'(power_eaten), 32'(m_pow));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic pixel(input int x, input int y, input bit bl, input logic [11:0] rgb);
    vin.hcount = 11'(x);
    vin.vcount = 11'(y);
    vin.hsync  = (x % 16) >= 8;
    vin.vsync  = (y % 8) >= 4;
    vin.blank  = bl;
    vin.rgb    = rgb;
  endtask

  task automatic eat(input int x, input int y);
    player_valid = 1'b1;
    player_x = 11'(x);
    player_y = 11'(y);
    @(negedge clk);
    player_valid = 1'b0;
  endtask

  task automatic pulse_level_start();
    level_start = 1'b1;
    @(negedge clk);
    level_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    pixel(0, 0, 1'b0, 12'h000);
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_left", 32'(pellets_left), 0);
    check("reset_clear", 32'(level_clear), 0);
    check("reset_eaten", 32'(pellet_eaten), 0);
    check("reset_rgb", 32'(vout.rgb), 0);
    rst = 1'b0;

    // Fill: PLAY and pellets_left=768 exactly TOTAL edges after level_start.
    repeat (6) @(negedge clk);
    pulse_level_start();
    repeat (TOTAL - 1) @(negedge clk);
    check("fill_not_done", 32'(pellets_left), 0);
    @(negedge clk);
    check("fill_done_left", 32'(pellets_left), 768);
    check("fill_done_clear", 32'(level_clear), 0);

    // Eat cell (3,1), repeat it, then an off-grid sample.
    eat(100, 40);
    check("eat_pulse", 32'(pellet_eaten), 1);
    check("eat_left", 32'(pellets_left), 767);
    @(negedge clk);
    check("eat_pulse_single", 32'(pellet_eaten), 0);
    eat(100, 40);
    check("reeat_pulse", 32'(pellet_eaten), 0);
    check("reeat_left", 32'(pellets_left), 767);
    eat(1100, 40);
    check("offgrid_left", 32'(pellets_left), 767);

    // Drawing: pellet centre, cell corner, blanking, outside the grid.
    pixel(16, 16, 1'b0, 12'h00F);
    repeat (2) @(negedge clk);
    check("pix_16_16", 32'(vout.rgb), 32'h0FB8);
    check("pix_16_16_h", 32'(vout.hcount), 16);
    pixel(0, 0, 1'b0, 12'h00F);
    repeat (2) @(negedge clk);
    check("pix_0_0", 32'(vout.rgb), 32'h000F);
    pixel(16, 16, 1'b1, 12'h00F);
    repeat (2) @(negedge clk);
    check("pix_blank", 32'(vout.rgb), 32'h000F);
    pixel(1040, 16, 1'b0, 12'h00F);
    repeat (2) @(negedge clk);
    check("pix_outside", 32'(vout.rgb), 32'h000F);

    // Small raster block, model-checked each cycle.
    for (int y = 12; y < 20; y++) begin
      for (int x = 0; x < 72; x++) begin
        pixel(x, y, (x % 37) == 36, 12'(x * 7 + y));
        @(negedge clk);
      end
    end

    // Mid-line eat of cell (2,0) while scanning its pellet row.
    for (int x = 0; x < 96; x++) begin
      pixel(x, 15, 1'b0, 12'h00F);
      if (x == 20) begin
        player_valid = 1'b1; player_x = 11'd70; player_y = 11'd10;
      end else begin
        player_valid = 1'b0;
      end
      @(negedge clk);
    end
    player_valid = 1'b0;
    pixel(78, 15, 1'b0, 12'h00F);
    repeat (2) @(negedge clk);
    check("eaten_mid_line", 32'(vout.rgb), 32'h000F);

    // Eat cell (0,0); its pellet disappears.
    eat(5, 5);
    pixel(16, 16, 1'b0, 12'h00F);
    repeat (2) @(negedge clk);
    check("pix_after_eat", 32'(vout.rgb), 32'h000F);
    check("left_after_3", 32'(pellets_left), 765);

    // Eat every cell in order.
    for (int i = 0; i < TOTAL; i++) begin
      player_valid = 1'b1;
      player_x = 11'((i % GRID_COLS) * CELL_SIZE + 7);
      player_y = 11'((i / GRID_COLS) * CELL_SIZE + 9);
      @(negedge clk);
    end
    player_valid = 1'b0;
    check("all_left", 32'(pellets_left), 0);
    check("all_clear", 32'(level_clear), 1);
    eat(200, 200);
    check("clear_ignores_player", 32'(pellet_eaten), 0);

    // Next level.
    pulse_level_start();
    check("restart_clear_drop", 32'(level_clear), 0);
    repeat (TOTAL - 1) @(negedge clk);
    check("refill_pending", 32'(pellets_left), 0);
    @(negedge clk);
    check("refill_left", 32'(pellets_left), 768);

    // Reset mid-fill at index 300.
    pulse_level_start();
    repeat (300) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_left", 32'(pellets_left), 0);
    check("rst_clear", 32'(level_clear), 0);
    check("rst_eaten", 32'(pellet_eaten), 0);
    check("rst_rgb", 32'(vout.rgb), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pixel(16, 16, 1'b0, 12'h00F);
    repeat (2) @(negedge clk);
    check("post_rst_no_pellet", 32'(vout.rgb), 32'h000F);
    repeat (20) @(negedge clk);
    check("post_rst_idle", 32'(pellets_left), 0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_pellets.md
# draw_pellets

Parametrised pellet layer for the maze game, placed in the VGA chain directly after the maze background stage. Holds a grid of pellet flags, refills it on each level start, clears pellets as the player position passes over them, and overlays the remaining pellets onto the incoming RGB stream. Reports eat events, pellets remaining and level-clear to the game control logic.

## Interface
- CELL_SIZE, 32: grid cell edge in pixels; power of two, at least 4.
- GRID_COLS, 32: cells per row.
- GRID_ROWS, 24: cells per column.
- PELLET_SIZE, 4: pellet square edge in pixels; even, smaller than CELL_SIZE.
- PELLET_RGB, 12'hF_B_8: pellet colour.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; asynchronous, active-high.
- vga_in  vga_if.in  timing and RGB from the previous stage.
- vga_out  vga_if.out  timing and RGB with pellets overlaid.
- level_start  in  1  single-cycle pulse; refill all pellets.
- player_valid  in  1  player_x and player_y are valid this cycle.
- player_x  in  11  player centre, x pixel.
- player_y  in  11  player centre, y pixel.
- pellet_eaten  out  1  single-cycle pulse, one per pellet removed.
- pellets_left  out  $clog2(GRID_COLS*GRID_ROWS+1)  remaining pellets.
- level_clear  out  1  high while in CLEAR.

## Operation
- Storage is a GRID_COLS*GRID_ROWS bit-vector of pellet flags. The index is row*GRID_COLS+col.
- The FSM has four states: IDLE, FILL, PLAY and CLEAR. Reset state is IDLE.
- IDLE: waits for level_start, then goes to FILL.
- FILL: a fill counter steps from 0 to TOTAL-1 and sets one flag per cycle. When the last flag is set, the FSM goes to PLAY and pellets_left loads TOTAL (GRID_COLS*GRID_ROWS).
- PLAY: eat rules.
  - Each cycle with player_valid high, col = player_x>>log2(CELL_SIZE) and row = player_y>>log2(CELL_SIZE).
  - If col >= GRID_COLS or row >= GRID_ROWS, the sample is ignored.
  - If the flag is set, it clears, pellets_left decrements, and pellet_eaten pulses.
  - If the flag is already clear, nothing happens.
  - If pellets_left goes from 1 to 0, the FSM goes to CLEAR.
- CLEAR: level_clear stays high. player_valid is ignored. level_start goes to FILL.
- level_start in any state restarts FILL from index 0, keeps existing flags as they are, and drops level_clear. During FILL, player_valid is ignored.
- If level_start and player_valid arrive in the same cycle, level_start wins and no eat occurs.
- Drawing, stage 1: registers the timing signals and the input rgb, plus the cell index and in-cell offset derived from hcount and vcount.
- Drawing, stage 2 (the output register):
  - Not blanking, pixel inside the grid, flag set, and offset within [CELL_SIZE/2-PELLET_SIZE/2, CELL_SIZE/2+PELLET_SIZE/2) on both axes: rgb = PELLET_RGB.
  - Otherwise the registered input rgb passes through.
- Flags are read live. A pellet eaten mid-frame disappears from the next pixel drawn after the clear.
- Pixels outside GRID_COLS*CELL_SIZE by GRID_ROWS*CELL_SIZE are never overlaid.
- Arithmetic:
  - The pellets_left decrement never underflows.
  - The fill counter width is $clog2(TOTAL).
  - The index multiply is a constant multiply and must not be built as a divider.

## Timing
- Reset values: all vga_out fields 0; pellet_eaten 0; pellets_left 0; level_clear 0; all flags 0; fill counter 0; FSM in IDLE.
- Reset asserted mid-FILL or mid-PLAY returns the block to IDLE immediately.
- Video latency: exactly 2 clk for every vga_out field relative to vga_in.
- level_start seen at edge N: FSM is in FILL after N. FSM is in PLAY after edge N+TOTAL, and pellets_left = TOTAL is visible from then.
- player_valid seen at edge N: the flag is cleared and pellets_left is updated at edge N. pellet_eaten is high for the one cycle after edge N.
- Last pellet eaten at edge N: level_clear is high from edge N.
- Eating at most one pellet per cycle.

## Configuration
- DRAW_PELLETS_POWER_EN defined: the four corner cells are power pellets.
  - The corner cells are (0,0), (GRID_COLS-1,0), (0,GRID_ROWS-1) and (GRID_COLS-1,GRID_ROWS-1).
  - Power pellets are drawn as 2*PELLET_SIZE squares.
  - Eating one also pulses an extra 1-bit output, power_eaten, in the same cycle as pellet_eaten.
- Not defined: corner cells are ordinary pellets and the power_eaten port does not exist.

## Test plan
- Reset, then level_start at cycle 10 -> PLAY and pellets_left=768 at cycle 778 (defaults); level_clear=0.
- PLAY, player_valid with (x=100, y=40) -> cell (3,1) cleared; pellet_eaten single pulse; pellets_left=767. Same position again -> no pulse, pellets_left stays 767.
- player_valid at (x=1100, y=40) -> ignored; pellets_left unchanged.
- Eat all 768 cells in sequence -> level_clear rises in the same cycle pellets_left reaches 0. A further level_start -> level_clear drops, and PLAY with pellets_left=768 follows 768 cycles later.
- Frame scan in PLAY with input rgb=12'h0_0_F -> output pixel (16,16)=12'hF_B_8 and (0,0)=12'h0_0_F. All vga_out fields lag by 2 clk. After cell (0,0) is eaten, pixel (16,16)=12'h0_0_F.
- Assert rst mid-FILL at index 300 -> all outputs 0 and FSM in IDLE immediately; no pellets drawn on the next frame.
